// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: 2-entry skid buffer (main = head, skid = overflow) with valid/ready handshake.
// Adds kill masking of side-effect control bits, synchronous flush, and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 64,
  parameter int                 CTRL_W    = 16,
  parameter logic [CTRL_W-1:0]  KILL_MASK = {CTRL_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_nop,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_bubble,
  output logic [1:0]        occupancy,
  output logic [15:0]       bp_cycles
);

  logic              main_vld_q, main_vld_d;
  logic [DATA_W-1:0] main_dat_q, main_dat_d;
  logic [CTRL_W-1:0] main_ctl_q, main_ctl_d;
  logic              main_bub_q, main_bub_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic [CTRL_W-1:0] skid_ctl_q, skid_ctl_d;
  logic              skid_bub_q, skid_bub_d;
  logic [15:0]       bp_q, bp_d;

  logic              in_xfer;
  logic              out_xfer;
  logic [CTRL_W-1:0] in_ctl_killed;

  // Ready comes only from registered state, so there is no comb path from out_ready.
  assign in_ready      = ~skid_vld_q;
  assign in_xfer       = in_valid & in_ready;
  assign out_xfer      = main_vld_q & out_ready;
  assign in_ctl_killed = in_ctrl & ~(KILL_MASK & {CTRL_W{in_nop}});

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    main_ctl_d = main_ctl_q;
    main_bub_d = main_bub_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    skid_ctl_d = skid_ctl_q;
    skid_bub_d = skid_bub_q;

    if (flush) begin
      main_vld_d = 1'b0;
      main_ctl_d = '0;
      main_bub_d = 1'b0;
      skid_vld_d = 1'b0;
      skid_ctl_d = '0;
      skid_bub_d = 1'b0;
    end else if (skid_vld_q) begin
      if (out_xfer) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        main_ctl_d = skid_ctl_q;
        main_bub_d = skid_bub_q;
        skid_vld_d = 1'b0;
      end
    end else if (main_vld_q) begin
      if (in_xfer && out_xfer) begin
        main_dat_d = in_data;
        main_ctl_d = in_ctl_killed;
        main_bub_d = in_nop;
      end else if (in_xfer) begin
        skid_vld_d = 1'b1;
        skid_dat_d = in_data;
        skid_ctl_d = in_ctl_killed;
        skid_bub_d = in_nop;
      end else if (out_xfer) begin
        main_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      main_vld_d = 1'b1;
      main_dat_d = in_data;
      main_ctl_d = in_ctl_killed;
      main_bub_d = in_nop;
    end
  end

  always_comb begin
    bp_d = bp_q;
    if (main_vld_q && !out_ready && bp_q != 16'hFFFF) begin
      bp_d = bp_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_dat_q <= '0;
      main_ctl_q <= '0;
      main_bub_q <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      skid_ctl_q <= '0;
      skid_bub_q <= 1'b0;
      bp_q       <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      main_ctl_q <= main_ctl_d;
      main_bub_q <= main_bub_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      skid_ctl_q <= skid_ctl_d;
      skid_bub_q <= skid_bub_d;
      bp_q       <= bp_d;
    end
  end

  assign out_valid  = main_vld_q;
  assign out_data   = main_dat_q;
  assign out_ctrl   = main_ctl_q & ~(KILL_MASK & {CTRL_W{~main_vld_q}});
  assign out_bubble = main_bub_q & main_vld_q;
  assign occupancy  = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
  assign bp_cycles  = bp_q;

endmodule
